// File: rtl/viterbi_pkg.sv
// Shared constants and FSM state type for the Viterbi survivor-memory scheduler.
package viterbi_pkg;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int NBANK = 4;

  typedef enum logic [2:0] {
    IDLE,
    FILL0,
    FILL1,
    FILL2,
    RUN
  } sched_state_e;

endpackage

// File: rtl/tb_sched.sv
// Survivor-memory scheduler: rotates writes over four banks and steers two
// traceback units between training and decoding in lockstep with the writes.
module tb_sched
  import viterbi_pkg::*;
#(
  parameter int DEPTH = viterbi_pkg::DEPTH,
  parameter int AW    = viterbi_pkg::AW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  output logic                       wr_en_mem,
  output logic [$clog2(NBANK)-1:0]   wr_bank,
  output logic [AW-1:0]              wr_addr,
  output logic [AW-1:0]              rd_addr,
  output logic [$clog2(NBANK)-1:0]   tb0_bank,
  output logic [$clog2(NBANK)-1:0]   tb1_bank,
  output logic                       tb0_en,
  output logic                       tb1_en,
  output logic                       tb0_sel,
  output logic                       tb1_sel,
  output logic                       abort
);

  localparam int BW = $clog2(NBANK);

  sched_state_e  state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, wrAddr_q, wrAddr_d, rdAddr_q, rdAddr_d;
  logic [BW-1:0] bank_q, bank_d, wrBank_q, wrBank_d;
  logic [1:0]    fill_q, fill_d;
  logic          wrEn_q, wrEn_d, abort_q, abort_d;
  logic          tb0En_q, tb0En_d, tb1En_q, tb1En_d;
  logic          tb0Sel_q, tb0Sel_d, tb1Sel_q, tb1Sel_d;
  logic [BW-1:0] tb0Bank_q, tb0Bank_d, tb1Bank_q, tb1Bank_d;
  logic          accept, brk, wrap, trainEn, decEn;
  logic [BW-1:0] trainBank, decBank;

  // A valid arriving while the abort pulse is still visible must not restart the stream.
  assign brk    = (state_q != IDLE) && !valid_in;
  assign accept = valid_in && ((state_q != IDLE) || !abort_q);
  assign wrap   = (state_q != IDLE) && (cnt_q == AW'(DEPTH - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bank_d   = bank_q;
    wrEn_d   = 1'b0;
    wrBank_d = wrBank_q;
    wrAddr_d = wrAddr_q;
    rdAddr_d = rdAddr_q;
    fill_d   = fill_q;
    abort_d  = 1'b0;
    if (brk) begin
      state_d  = IDLE;
      cnt_d    = '0;
      bank_d   = '0;
      wrBank_d = '0;
      wrAddr_d = '0;
      rdAddr_d = AW'(DEPTH - 1);
      fill_d   = '0;
      abort_d  = 1'b1;
    end else if (accept) begin
      wrEn_d   = 1'b1;
      wrAddr_d = cnt_q;
      rdAddr_d = AW'(DEPTH - 1) - cnt_q;
      wrBank_d = bank_q;
      cnt_d    = cnt_q + AW'(1);
      unique case (state_q)
        FILL1:   fill_d = 2'd1;
        FILL2:   fill_d = 2'd2;
        RUN:     fill_d = 2'd3;
        default: fill_d = 2'd0;
      endcase
      if (state_q == IDLE) begin
        state_d = FILL0;
      end else if (wrap) begin
        bank_d = bank_q + BW'(1);
        unique case (state_q)
          FILL0:   state_d = FILL1;
          FILL1:   state_d = FILL2;
          default: state_d = RUN;
        endcase
      end
    end
  end

  // Trainer is the unit matching the period parity (bank LSB); the decoder is
  // the other one, and only exists once three full banks are behind us.
  always_comb begin
    trainEn   = wrEn_q && (fill_q != 2'd0);
    decEn     = wrEn_q && (fill_q == 2'd3);
    trainBank = wrBank_q - BW'(1);
    decBank   = wrBank_q + BW'(1);
    tb0En_d   = 1'b0;
    tb0Sel_d  = 1'b0;
    tb0Bank_d = '0;
    tb1En_d   = 1'b0;
    tb1Sel_d  = 1'b0;
    tb1Bank_d = '0;
    if (!brk) begin
      if (!wrBank_q[0]) begin
        tb0En_d   = trainEn;
        tb0Bank_d = trainEn ? trainBank : '0;
        tb1En_d   = decEn;
        tb1Sel_d  = decEn;
        tb1Bank_d = decEn ? decBank : '0;
      end else begin
        tb1En_d   = trainEn;
        tb1Bank_d = trainEn ? trainBank : '0;
        tb0En_d   = decEn;
        tb0Sel_d  = decEn;
        tb0Bank_d = decEn ? decBank : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bank_q    <= '0;
      wrEn_q    <= 1'b0;
      wrBank_q  <= '0;
      wrAddr_q  <= '0;
      rdAddr_q  <= AW'(DEPTH - 1);
      fill_q    <= '0;
      abort_q   <= 1'b0;
      tb0En_q   <= 1'b0;
      tb0Sel_q  <= 1'b0;
      tb0Bank_q <= '0;
      tb1En_q   <= 1'b0;
      tb1Sel_q  <= 1'b0;
      tb1Bank_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bank_q    <= bank_d;
      wrEn_q    <= wrEn_d;
      wrBank_q  <= wrBank_d;
      wrAddr_q  <= wrAddr_d;
      rdAddr_q  <= rdAddr_d;
      fill_q    <= fill_d;
      abort_q   <= abort_d;
      tb0En_q   <= tb0En_d;
      tb0Sel_q  <= tb0Sel_d;
      tb0Bank_q <= tb0Bank_d;
      tb1En_q   <= tb1En_d;
      tb1Sel_q  <= tb1Sel_d;
      tb1Bank_q <= tb1Bank_d;
    end
  end

  assign wr_en_mem = wrEn_q;
  assign wr_bank   = wrBank_q;
  assign wr_addr   = wrAddr_q;
  assign rd_addr   = rdAddr_q;
  assign abort     = abort_q;
  assign tb0_en    = tb0En_q;
  assign tb0_sel   = tb0Sel_q;
  assign tb0_bank  = tb0Bank_q;
  assign tb1_en    = tb1En_q;
  assign tb1_sel   = tb1Sel_q;
  assign tb1_bank  = tb1Bank_q;

endmodule

// File: tb/tb_tb_sched.sv
// Directed bench for tb_sched: a vector-index reference model feeds a
// scoreboard of expected per-cycle outputs, plus spot checks at period edges.
module tb_tb_sched;
  import viterbi_pkg::*;

  typedef struct packed {
    logic          abort;
    logic          wrEn;
    logic [1:0]    wrBank;
    logic [AW-1:0] wrAddr;
    logic [AW-1:0] rdAddr;
    logic          tb0En;
    logic          tb0Sel;
    logic [1:0]    tb0Bank;
    logic          tb1En;
    logic          tb1Sel;
    logic [1:0]    tb1Bank;
  } out_t;

  localparam out_t RESET_VAL = '{abort: 1'b0, wrEn: 1'b0, wrBank: 2'd0, wrAddr: '0,
                                 rdAddr: AW'(DEPTH - 1), tb0En: 1'b0, tb0Sel: 1'b0,
                                 tb0Bank: 2'd0, tb1En: 1'b0, tb1Sel: 1'b0, tb1Bank: 2'd0};

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic          wr_en_mem, tb0_en, tb1_en, tb0_sel, tb1_sel, abort;
  logic [1:0]    wr_bank, tb0_bank, tb1_bank;
  logic [AW-1:0] wr_addr, rd_addr;

  int   checks = 0;
  int   errors = 0;
  out_t sb[$];

  int mCount, mPrevCount;
  bit mActive, mPrevValid, mAbortPrev;

  tb_sched #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .wr_en_mem(wr_en_mem), .wr_bank(wr_bank), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .tb0_bank(tb0_bank), .tb1_bank(tb1_bank), .tb0_en(tb0_en), .tb1_en(tb1_en),
    .tb0_sel(tb0_sel), .tb1_sel(tb1_sel), .abort(abort)
  );

  always #5 clk = ~clk;

  function automatic out_t sampleDut();
    out_t s;
    s.abort = abort;     s.wrEn = wr_en_mem;  s.wrBank = wr_bank;
    s.wrAddr = wr_addr;  s.rdAddr = rd_addr;
    s.tb0En = tb0_en;    s.tb0Sel = tb0_sel;  s.tb0Bank = tb0_bank;
    s.tb1En = tb1_en;    s.tb1Sel = tb1_sel;  s.tb1Bank = tb1_bank;
    return s;
  endfunction

  // Traceback roles for the vector with stream index k, seen one cycle after its write.
  function automatic out_t addTraceback(input out_t e, input int k);
    int p, bank;
    p    = k / DEPTH;
    bank = p % 4;
    if (p >= 1) begin
      if (p % 2 == 0) begin
        e.tb0En = 1'b1; e.tb0Sel = 1'b0; e.tb0Bank = 2'((bank + 3) % 4);
      end else begin
        e.tb1En = 1'b1; e.tb1Sel = 1'b0; e.tb1Bank = 2'((bank + 3) % 4);
      end
    end
    if (p >= 3) begin
      if (p % 2 == 0) begin
        e.tb1En = 1'b1; e.tb1Sel = 1'b1; e.tb1Bank = 2'((bank + 1) % 4);
      end else begin
        e.tb0En = 1'b1; e.tb0Sel = 1'b1; e.tb0Bank = 2'((bank + 1) % 4);
      end
    end
    return e;
  endfunction

  function automatic void modelReset();
    mCount = 0; mPrevCount = 0;
    mActive = 1'b0; mPrevValid = 1'b0; mAbortPrev = 1'b0;
  endfunction

  task automatic checkOutput(input string tag);
    out_t got, exp;
    got = sampleDut();
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, got %h", tag, got);
    end else begin
      exp = sb.pop_front();
      assert (got === exp) else begin
        errors++;
        $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
    end
  endtask

  task automatic checkField(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input string tag);
    out_t e;
    @(negedge clk);
    valid_in = v;
    e = RESET_VAL;
    if (mActive && !v) begin
      e.abort = 1'b1;
      mActive = 1'b0; mCount = 0; mPrevValid = 1'b0;
    end else if (v && (mActive || !mAbortPrev)) begin
      e.wrEn   = 1'b1;
      e.wrAddr = AW'(mCount % DEPTH);
      e.rdAddr = AW'(DEPTH - 1 - (mCount % DEPTH));
      e.wrBank = 2'((mCount / DEPTH) % 4);
      if (mPrevValid) e = addTraceback(e, mPrevCount);
      mPrevCount = mCount; mPrevValid = 1'b1; mActive = 1'b1;
      mCount++;
    end else begin
      mPrevValid = 1'b0;
    end
    mAbortPrev = e.abort;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic streamVectors(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, tag);
  endtask

  initial begin
    logic prevTb0Sel;
    rst = 1'b0;
    valid_in = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(RESET_VAL);
    checkOutput("reset");
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(1'b0, "idle");
    applyStimulus(1'b0, "idle");

    $display("[TB] fill and run through four periods");
    prevTb0Sel = 1'b0;
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'b1, $sformatf("vec%0d", k));
      if (k == 0) begin
        checkField("first wr_addr", 32'(wr_addr), 0);
        checkField("first rd_addr", 32'(rd_addr), 63);
      end
      if (k == 63) begin
        checkField("fill end wr_addr", 32'(wr_addr), 63);
        checkField("fill end rd_addr", 32'(rd_addr), 0);
        checkField("fill tb0_en", 32'(tb0_en), 0);
        checkField("fill tb1_en", 32'(tb1_en), 0);
      end
      if (k == 65) begin
        checkField("p1 tb1_en", 32'(tb1_en), 1);
        checkField("p1 tb1_sel", 32'(tb1_sel), 0);
        checkField("p1 tb1_bank", 32'(tb1_bank), 0);
        checkField("p1 tb0_en", 32'(tb0_en), 0);
      end
      if (k == 129) begin
        checkField("p2 tb0_en", 32'(tb0_en), 1);
        checkField("p2 tb0_sel", 32'(tb0_sel), 0);
        checkField("p2 tb0_bank", 32'(tb0_bank), 1);
        checkField("p2 tb1_en", 32'(tb1_en), 0);
      end
      if (k == 192) checkField("p3 wr_bank", 32'(wr_bank), 3);
      if (k == 193) begin
        checkField("p3 tb1_bank", 32'(tb1_bank), 2);
        checkField("p3 tb1_sel", 32'(tb1_sel), 0);
        checkField("p3 tb0_bank", 32'(tb0_bank), 0);
        checkField("p3 tb0_sel", 32'(tb0_sel), 1);
      end
      if (k == 256) begin
        checkField("p4 wr_bank", 32'(wr_bank), 0);
        prevTb0Sel = tb0_sel;
      end
      if (k == 257) begin
        checkField("p4 tb0_sel before", 32'(prevTb0Sel), 1);
        checkField("p4 tb0_sel", 32'(tb0_sel), 0);
        checkField("p4 tb0_bank", 32'(tb0_bank), 3);
        checkField("p4 tb1_sel", 32'(tb1_sel), 1);
        checkField("p4 tb1_bank", 32'(tb1_bank), 1);
      end
    end

    $display("[TB] break in RUN, valid during abort ignored");
    applyStimulus(1'b0, "run break");
    checkField("run break abort", 32'(abort), 1);
    applyStimulus(1'b1, "abort cycle valid");
    checkField("ignored wr_en", 32'(wr_en_mem), 0);
    checkField("abort one cycle", 32'(abort), 0);

    $display("[TB] break at vector 100");
    streamVectors(100, "stream100");
    applyStimulus(1'b0, "break100");
    checkField("break100 abort", 32'(abort), 1);
    checkField("break100 tb1_en", 32'(tb1_en), 0);
    applyStimulus(1'b0, "post break idle");
    applyStimulus(1'b1, "restart");
    checkField("restart wr_addr", 32'(wr_addr), 0);
    checkField("restart wr_bank", 32'(wr_bank), 0);

    $display("[TB] break at the wrap cycle of period 3");
    streamVectors(254, "stream255");
    checkField("prewrap wr_addr", 32'(wr_addr), 62);
    checkField("prewrap wr_bank", 32'(wr_bank), 3);
    applyStimulus(1'b0, "wrap break");
    checkField("wrap break abort", 32'(abort), 1);
    checkField("wrap break wr_bank", 32'(wr_bank), 0);
    applyStimulus(1'b0, "wrap idle");
    applyStimulus(1'b1, "wrap restart");
    checkField("wrap restart tb0_en", 32'(tb0_en), 0);

    $display("[TB] reset mid-stream");
    streamVectors(70, "stream70");
    @(negedge clk);
    valid_in = 1'b1;
    rst = 1'b0;
    #1;
    sb.push_back(RESET_VAL);
    checkOutput("async reset");
    @(posedge clk);
    #1;
    sb.push_back(RESET_VAL);
    checkOutput("held reset");
    @(negedge clk);
    rst = 1'b1;
    valid_in = 1'b0;
    modelReset();
    applyStimulus(1'b0, "post reset idle");
    checkField("post reset abort", 32'(abort), 0);
    streamVectors(3, "post reset stream");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
